// File: rtl/hb_pkg.sv
//==== hb_pkg -- shared types and constants for the heartbeat monitor (rev 1.0) ====
`default_nettype none

package hb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } hb_state_t;

    localparam int ERR_W = 16;

endpackage : hb_pkg

`default_nettype wire

// File: rtl/hb_sync.sv
//==== hb_sync -- two-flop synchronizer plus history flop, any-edge detect (rev 1.0) ====
`default_nettype none

module hb_sync (
    input  logic clk,
    input  logic rst,
    input  logic hb_in,
    output logic hb_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= hb_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign hb_edge = r_s2 ^ r_s3;

endmodule : hb_sync

`default_nettype wire

// File: rtl/hb_monitor.sv
//==== hb_monitor -- heartbeat half-period checker: lock/lost status, error count, LED (rev 1.0) ====
`default_nettype none

module hb_monitor
    import hb_pkg::*;
#(
    parameter int CNT_W     = 28,
    parameter int MIN_HALF  = 13_000_000,
    parameter int MAX_HALF  = 15_000_000,
    parameter int LOCK_CNT  = 4,
    parameter int BLINK_BIT = 22
) (
    input  logic             bd_fclk0_125m,
    input  logic             reset,
    input  logic             hb_in,
    output logic             hb_locked,
    output logic             hb_lost,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_half,
    output logic [ERR_W-1:0] err_cnt,
    output logic             status_led
);

    localparam int                GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  C_MIN  = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0]  C_MAX  = CNT_W'(MAX_HALF);
    localparam logic [CNT_W-1:0]  C_SAT  = '1;
    localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);
    localparam logic [GOOD_W-1:0] C_LOCK = GOOD_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0]  C_ESAT = '1;

    hb_state_t            r_state;
    logic [CNT_W-1:0]     r_half_cnt;
    logic [GOOD_W-1:0]    r_good_cnt;
    logic [ERR_W-1:0]     r_err_cnt;
    logic                 r_meas_valid;
    logic [CNT_W-1:0]     r_meas_half;
    logic [BLINK_BIT:0]   r_blink_cnt;

    logic                 w_edge;
    logic                 w_in_window;
    logic                 w_timeout;
    logic                 w_err_inc;
    logic [GOOD_W-1:0]    w_good_next;

    hb_sync u_sync (
        .clk     (bd_fclk0_125m),
        .rst     (reset),
        .hb_in   (hb_in),
        .hb_edge (w_edge)
    );

    // On an edge cycle r_half_cnt still holds the just-finished half-period.
    assign w_in_window = (r_half_cnt >= C_MIN) && (r_half_cnt <= C_MAX);
    assign w_timeout   = !w_edge && (r_half_cnt > C_MAX);
    assign w_good_next = r_good_cnt + GOOD_W'(1);
    assign w_err_inc   = (r_state == LOCKED) && ((w_edge && !w_in_window) || w_timeout);

    always_ff @(posedge bd_fclk0_125m) begin
        if (reset) begin
            r_state      <= IDLE;
            r_half_cnt   <= '0;
            r_good_cnt   <= '0;
            r_err_cnt    <= '0;
            r_meas_valid <= 1'b0;
            r_meas_half  <= '0;
            r_blink_cnt  <= '0;
        end else begin
            r_blink_cnt  <= r_blink_cnt + (BLINK_BIT + 1)'(1);
            r_meas_valid <= 1'b0;

            if (w_edge) begin
                r_half_cnt <= C_ONE;
            end else if (r_half_cnt != C_SAT) begin
                r_half_cnt <= r_half_cnt + C_ONE;
            end

            if (w_edge && (r_state == ACQ || r_state == LOCKED)) begin
                r_meas_valid <= 1'b1;
                r_meas_half  <= r_half_cnt;
            end

            if (w_err_inc && (r_err_cnt != C_ESAT)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end

            case (r_state)
                IDLE, LOST: begin
                    if (w_edge) begin
                        r_state    <= ACQ;
                        r_good_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state <= LOST;
                    end
                end
                ACQ: begin
                    if (w_edge) begin
                        if (!w_in_window) begin
                            r_good_cnt <= '0;
                        end else if (w_good_next == C_LOCK) begin
                            r_state    <= LOCKED;
                            r_good_cnt <= '0;
                        end else begin
                            r_good_cnt <= w_good_next;
                        end
                    end else if (w_timeout) begin
                        r_state <= LOST;
                    end
                end
                LOCKED: begin
                    if (w_edge) begin
                        if (!w_in_window) begin
                            r_state    <= ACQ;
                            r_good_cnt <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state <= LOST;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        status_led = r_blink_cnt[BLINK_BIT];
        case (r_state)
            LOCKED:  status_led = 1'b1;
            LOST:    status_led = 1'b0;
            default: status_led = r_blink_cnt[BLINK_BIT];
        endcase
    end

    assign hb_locked  = (r_state == LOCKED);
    assign hb_lost    = (r_state == LOST);
    assign meas_valid = r_meas_valid;
    assign meas_half  = r_meas_half;
    assign err_cnt    = r_err_cnt;

endmodule : hb_monitor

`default_nettype wire

// File: tb/tb_hb_monitor.sv
//==== tb_hb_monitor -- scoreboard bench: per-half-period reference model vs. hb_monitor (rev 1.0) ====
`default_nettype none

module tb_hb_monitor;

    localparam int CNT_W     = 8;
    localparam int MIN_HALF  = 8;
    localparam int MAX_HALF  = 12;
    localparam int LOCK_CNT  = 3;
    localparam int BLINK_BIT = 2;

    // Model states (bench-local numbering)
    localparam int M_IDLE = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;
    localparam int M_LOST = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             hb_in = 1'b0;
    logic             hb_locked;
    logic             hb_lost;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_half;
    logic [15:0]      err_cnt;
    logic             status_led;

    hb_monitor #(
        .CNT_W     (CNT_W),
        .MIN_HALF  (MIN_HALF),
        .MAX_HALF  (MAX_HALF),
        .LOCK_CNT  (LOCK_CNT),
        .BLINK_BIT (BLINK_BIT)
    ) dut (
        .bd_fclk0_125m (clk),
        .reset         (reset),
        .hb_in         (hb_in),
        .hb_locked     (hb_locked),
        .hb_lost       (hb_lost),
        .meas_valid    (meas_valid),
        .meas_half     (meas_half),
        .err_cnt       (err_cnt),
        .status_led    (status_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mv;
        logic [7:0]  half;
        bit          locked;
        bit          lost;
        logic [15:0] err;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;
    logic [17:0] cur;
    logic [17:0] prev = '0;

    int m_st   = M_IDLE;
    int m_good = 0;
    int m_err  = 0;

    function automatic bit in_win(int d);
        return (d >= MIN_HALF) && (d <= MAX_HALF);
    endfunction

    task automatic push(bit mv, int half);
        exp_t x;
        x.mv     = mv;
        x.half   = half[7:0];
        x.locked = (m_st == M_LOCK);
        x.lost   = (m_st == M_LOST);
        x.err    = m_err[15:0];
        q.push_back(x);
    endtask

    task automatic err_up();
        if (m_err < 16'hFFFF) m_err = m_err + 1;
    endtask

    // Effect of one half-period of d cycles, optionally closed by an edge.
    task automatic model_gap(int d, bit toggles);
        if (d >= MAX_HALF + 2 && m_st != M_LOST) begin
            if (m_st == M_LOCK) err_up();
            m_st = M_LOST;
            push(1'b0, 0);
        end
        if (toggles) begin
            case (m_st)
                M_IDLE: begin
                    m_st = M_ACQ; m_good = 0;
                end
                M_LOST: begin
                    m_st = M_ACQ; m_good = 0;
                    push(1'b0, 0);
                end
                M_ACQ: begin
                    if (in_win(d)) begin
                        m_good = m_good + 1;
                        if (m_good == LOCK_CNT) m_st = M_LOCK;
                    end else begin
                        m_good = 0;
                    end
                    push(1'b1, d);
                end
                default: begin
                    if (!in_win(d)) begin
                        m_st = M_ACQ; m_good = 0;
                        err_up();
                    end
                    push(1'b1, d);
                end
            endcase
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Toggle hb_in d cycles after the previous toggle; spot-check settled status.
    task automatic gap(int d);
        int pre;
        pre = m_st;
        model_gap(d, 1'b1);
        for (int i = 1; i <= d; i++) begin
            @(negedge clk);
            if (i == 4 && d >= 6 && pre != M_IDLE) begin
                check("locked_settled", 32'(hb_locked), 32'(pre == M_LOCK));
                check("lost_settled", 32'(hb_lost), 32'(pre == M_LOST));
                if (pre == M_LOCK) check("led_locked", 32'(status_led), 32'd1);
                if (pre == M_LOST) check("led_lost", 32'(status_led), 32'd0);
            end
            if (i == d - 1 && d >= 18) begin
                check("lost_after_timeout", 32'(hb_lost), 32'd1);
                check("unlocked_after_timeout", 32'(hb_locked), 32'd0);
                check("led_after_timeout", 32'(status_led), 32'd0);
            end
        end
        hb_in = ~hb_in;
    endtask

    // Reset for one cycle with hb_in parked low, then check reset state and IDLE blink.
    task automatic do_reset();
        check("queue_drained", 32'(q.size()), 32'd0);
        mon_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        hb_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_st = M_IDLE; m_good = 0; m_err = 0;
        check("rst_outputs", {26'd0, meas_valid, hb_locked, hb_lost, status_led, (meas_half != 8'd0), (err_cnt != 16'd0)}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("idle_blink", 32'(status_led), 32'((k >> BLINK_BIT) & 1));
        end
        mon_en = 1'b1;
        // Edge cycle lands with half_cnt = 7: no IDLE timeout.
        model_gap(7, 1'b1);
        hb_in = ~hb_in;
    endtask

    task automatic drain();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(posedge clk);
                #2;
                cur = {hb_locked, hb_lost, err_cnt};
                if (mon_en && (meas_valid || cur != prev)) begin
                    vectors = vectors + 1;
                    if (q.size() == 0) begin
                        miscompares = miscompares + 1;
                        $display("FAIL unexpected_event: got mv=%0b half=%0d locked=%0b lost=%0b err=%0h, required no event (t=%0t)",
                                 meas_valid, meas_half, hb_locked, hb_lost, err_cnt, $time);
                    end else begin
                        e = q.pop_front();
                        if (meas_valid !== e.mv || (e.mv && meas_half !== e.half) || hb_locked !== e.locked
                            || hb_lost !== e.lost || err_cnt !== e.err) begin
                            miscompares = miscompares + 1;
                            $display("FAIL event: got mv=%0b half=%0d locked=%0b lost=%0b err=%0h, required mv=%0b half=%0d locked=%0b lost=%0b err=%0h (t=%0t)",
                                     meas_valid, meas_half, hb_locked, hb_lost, err_cnt,
                                     e.mv, e.half, e.locked, e.lost, e.err, $time);
                        end
                    end
                end
                prev = cur;
            end
        join_none

        // Lock at period 10, then stop toggling.
        do_reset();
        repeat (5) gap(10);
        gap(30);

        // Window bounds.
        repeat (4) gap(12);
        repeat (3) gap(13);
        repeat (2) gap(14);
        repeat (4) gap(8);
        repeat (4) gap(7);

        // Short glitch while locked, then relock.
        repeat (3) gap(10);
        gap(5);
        repeat (3) gap(10);

        // Reset mid-lock: full reacquisition required.
        drain();
        do_reset();
        repeat (4) gap(10);

        // Error counter saturation.
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        force dut.r_err_cnt = 16'hFFFE;
        m_err = 16'hFFFE;
        @(negedge clk);
        release dut.r_err_cnt;
        mon_en = 1'b1;
        check("err_preset", 32'(err_cnt), 32'h0000FFFE);
        model_gap(10, 1'b1);
        repeat (4) @(negedge clk);
        hb_in = ~hb_in;
        gap(5);
        repeat (3) gap(10);
        gap(5);
        repeat (3) gap(10);
        gap(30);
        drain();
        check("err_saturated", 32'(err_cnt), 32'h0000FFFF);

        // Randomized half-periods with occasional resets.
        for (int n = 0; n < 150; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55)      gap($urandom_range(MIN_HALF, MAX_HALF));
            else if (r < 82) gap($urandom_range(3, 14));
            else if (r < 97) gap($urandom_range(15, 22));
            else begin
                drain();
                do_reset();
            end
        end

        drain();
        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_hb_monitor

`default_nettype wire
